axil_reg_responder: RTL and testbench

- AXI4-Lite slave (responder) register bank for the mat_mult IP.
- Terminates the S00_AXI transactions issued by the AXI VIP master: single-beat writes with byte strobes, single-beat reads.
- Exposes register contents and per-register write pulses to the matrix-multiply datapath.
- One write and one read in flight at a time; write and read channels are independent.

---
 rtl/axil_reg_responder.sv | 218 +++++++++++++++++++++
 tb/tb_axil_reg_responder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_reg_responder.sv
// rtl/axil_reg_responder.sv - AXI4-Lite register bank with per-register write pulses.
// Optional AXIL_REG_DECERR_EN: out-of-range accesses answer SLVERR instead of OKAY.
module axil_reg_responder #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int C_NUM_REGS         = 4
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [C_NUM_REGS*32-1:0]          reg_out,
  output logic [C_NUM_REGS-1:0]             reg_wr
);

  localparam int IDX_W  = C_S_AXI_ADDR_WIDTH - 2;
  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_REG_DECERR_EN
  localparam logic [1:0] RESP_OOR = 2'b10;
`else
  localparam logic [1:0] RESP_OOR = 2'b00;
`endif

  typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t                                 w_state_q, w_state_d;
  r_state_t                                 r_state_q, r_state_d;
  logic                                     awready_q, awready_d;
  logic                                     wready_q, wready_d;
  logic                                     bvalid_q, bvalid_d;
  logic [1:0]                               bresp_q, bresp_d;
  logic [IDX_W-1:0]                         waddr_q, waddr_d;
  logic [C_S_AXI_DATA_WIDTH-1:0]            wdata_q, wdata_d;
  logic [STRB_W-1:0]                        wstrb_q, wstrb_d;
  logic [C_NUM_REGS-1:0][31:0]              regs_q, regs_d;
  logic [C_NUM_REGS-1:0]                    reg_wr_q, reg_wr_d;
  logic                                     arready_q, arready_d;
  logic                                     rvalid_q, rvalid_d;
  logic [1:0]                               rresp_q, rresp_d;
  logic [C_S_AXI_DATA_WIDTH-1:0]            rdata_q, rdata_d;

  logic                                     aw_hs, w_hs, ar_hs;
  logic [IDX_W-1:0]                         aw_idx, ar_idx;
  logic                                     commit;
  logic [IDX_W-1:0]                         c_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0]            c_data;
  logic [STRB_W-1:0]                        c_strb;
  logic                                     unused_ok;

  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return 32'(idx) < 32'(C_NUM_REGS);
  endfunction

  assign aw_hs  = S_AXI_AWVALID && awready_q;
  assign w_hs   = S_AXI_WVALID && wready_q;
  assign ar_hs  = S_AXI_ARVALID && arready_q;
  assign aw_idx = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign ar_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  always_comb begin
    w_state_d = w_state_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    regs_d    = regs_q;
    reg_wr_d  = '0;
    commit    = 1'b0;
    c_idx     = waddr_q;
    c_data    = wdata_q;
    c_strb    = wstrb_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit = 1'b1;
          c_idx  = aw_idx;
          c_data = S_AXI_WDATA;
          c_strb = S_AXI_WSTRB;
        end else if (aw_hs) begin
          waddr_d   = aw_idx;
          w_state_d = W_HAVE_A;
        end else if (w_hs) begin
          wdata_d   = S_AXI_WDATA;
          wstrb_d   = S_AXI_WSTRB;
          w_state_d = W_HAVE_D;
        end
      end
      W_HAVE_A: begin
        if (w_hs) begin
          commit = 1'b1;
          c_data = S_AXI_WDATA;
          c_strb = S_AXI_WSTRB;
        end
      end
      W_HAVE_D: begin
        if (aw_hs) begin
          commit = 1'b1;
          c_idx  = aw_idx;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    // Out-of-range writes still complete the handshake but touch nothing.
    if (commit) begin
      w_state_d = W_RESP;
      if (in_range(c_idx)) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (c_strb[b]) regs_d[c_idx][8*b +: 8] = c_data[8*b +: 8];
        end
        reg_wr_d[c_idx] = 1'b1;
        bresp_d         = RESP_OKAY;
      end else begin
        bresp_d = RESP_OOR;
      end
    end
    awready_d = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_D);
    wready_d  = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_A);
    bvalid_d  = (w_state_d == W_RESP);
  end

  // Reads sample regs_q, so a same-cycle commit is not yet visible.
  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          if (in_range(ar_idx)) begin
            rdata_d = regs_q[ar_idx];
            rresp_d = RESP_OKAY;
          end else begin
            rdata_d = '0;
            rresp_d = RESP_OOR;
          end
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      waddr_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      regs_q    <= '0;
      reg_wr_q  <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      regs_q    <= regs_d;
      reg_wr_q  <= reg_wr_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign reg_out       = regs_q;
  assign reg_wr        = reg_wr_q;

endmodule

// File: tb/tb_axil_reg_responder.sv
// tb/tb_axil_reg_responder.sv - scoreboard bench for axil_reg_responder (4-reg and 3-reg instances).
module tb_axil_reg_responder;

`ifdef AXIL_REG_DECERR_EN
  localparam logic [1:0] OOR = 2'b10;
`else
  localparam logic [1:0] OOR = 2'b00;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;

  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [127:0] reg_out;
  logic [3:0]  reg_wr;

  logic        awready3, wready3, bvalid3, arready3, rvalid3;
  logic [1:0]  bresp3, rresp3;
  logic [31:0] rdata3;
  logic [95:0] reg_out3;
  logic [2:0]  reg_wr3;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  r;
    logic [31:0] d3;
    logic [1:0]  r3;
  } r_exp_t;

  logic [3:0]  exp_wr[$];
  logic [3:0]  exp_b[$];
  r_exp_t      exp_r[$];
  logic [31:0] mdl[4];

  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  axil_reg_responder u_dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_out(reg_out), .reg_wr(reg_wr)
  );

  axil_reg_responder #(.C_NUM_REGS(3)) u_dut3 (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready3),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready3),
    .S_AXI_BRESP(bresp3), .S_AXI_BVALID(bvalid3), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready3),
    .S_AXI_RDATA(rdata3), .S_AXI_RRESP(rresp3), .S_AXI_RVALID(rvalid3), .S_AXI_RREADY(rready),
    .reg_out(reg_out3), .reg_wr(reg_wr3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [3:0] mon_wr;
  logic [3:0] mon_b;
  r_exp_t     mon_r;

  always @(negedge clk) begin
    if (rst_n) begin
      if (reg_wr != 4'b0 || reg_wr3 != 3'b0) begin
        if (exp_wr.size() == 0) begin
          check("wr_unexpected", 32'(reg_wr), 32'd0);
        end else begin
          mon_wr = exp_wr.pop_front();
          check("reg_wr", 32'(reg_wr), 32'(mon_wr));
          check("reg_wr3", 32'(reg_wr3), 32'(mon_wr[2:0]));
          check("wr_with_bvalid", 32'(bvalid), 32'd1);
        end
      end
      if (bvalid && bready) begin
        if (exp_b.size() == 0) begin
          check("b_unexpected", 32'(bvalid), 32'd0);
        end else begin
          mon_b = exp_b.pop_front();
          check("bresp", 32'(bresp), 32'(mon_b[1:0]));
          check("bresp3", 32'(bresp3), 32'(mon_b[3:2]));
          check("bvalid3", 32'(bvalid3), 32'd1);
        end
      end
      if (rvalid && rready) begin
        if (exp_r.size() == 0) begin
          check("r_unexpected", 32'(rvalid), 32'd0);
        end else begin
          mon_r = exp_r.pop_front();
          check("rdata", rdata, mon_r.d);
          check("rresp", 32'(rresp), 32'(mon_r.r));
          check("rdata3", rdata3, mon_r.d3);
          check("rresp3", 32'(rresp3), 32'(mon_r.r3));
        end
      end
    end
  end

  task automatic aw_phase(input logic [3:0] addr, input int dly);
    int n;
    repeat (dly) begin @(posedge clk); #1; end
    awaddr = addr; awvalid = 1'b1; n = 0;
    do begin @(negedge clk); n++; end while (!awready && n < 50);
    if (!awready) check("aw_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic w_phase(input logic [31:0] data, input logic [3:0] strb, input int dly);
    int n;
    repeat (dly) begin @(posedge clk); #1; end
    wdata = data; wstrb = strb; wvalid = 1'b1; n = 0;
    do begin @(negedge clk); n++; end while (!wready && n < 50);
    if (!wready) check("w_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    wvalid = 1'b0;
  endtask

  task automatic wait_bresp();
    int n = 0;
    while (!(bvalid && bready) && n < 200) begin @(negedge clk); n++; end
    if (!(bvalid && bready)) check("b_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input bit wait_b);
    logic [1:0] idx;
    idx = addr[3:2];
    exp_wr.push_back(4'b0001 << idx);
    exp_b.push_back({(idx == 2'd3) ? OOR : 2'b00, 2'b00});
    for (int b = 0; b < 4; b++) if (strb[b]) mdl[idx][8*b +: 8] = data[8*b +: 8];
    fork
      aw_phase(addr, aw_dly);
      w_phase(data, strb, w_dly);
    join
    @(negedge clk);
    check("b_latency", 32'(bvalid), 32'd1);
    if (wait_b) wait_bresp();
  endtask

  task automatic do_read(input logic [3:0] addr, input logic [31:0] exp);
    logic [1:0] idx;
    r_exp_t     e;
    int         n;
    idx  = addr[3:2];
    e.d  = exp;
    e.r  = 2'b00;
    e.d3 = (idx == 2'd3) ? 32'd0 : exp;
    e.r3 = (idx == 2'd3) ? OOR : 2'b00;
    exp_r.push_back(e);
    araddr = addr; arvalid = 1'b1; n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < 50);
    if (!arready) check("ar_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    check("r_latency", 32'(rvalid), 32'd1);
    n = 0;
    while (!(rvalid && rready) && n < 200) begin @(negedge clk); n++; end
    if (!(rvalid && rready)) check("r_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    wdata = '0; wstrb = '0; bready = 1'b1; rready = 1'b1;
    for (int i = 0; i < 4; i++) mdl[i] = '0;

    repeat (2) @(negedge clk);
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_reg_out", 32'(reg_out != '0), 32'd0);
    check("rst_reg_wr", 32'(reg_wr), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    do_write(4'h0, 32'h1, 4'hF, 0, 0, 1);
    do_write(4'h4, 32'h2, 4'hF, 0, 0, 1);
    do_write(4'h8, 32'h3, 4'hF, 0, 0, 1);
    do_write(4'hC, 32'h4, 4'hF, 0, 0, 1);
    do_read(4'h0, 32'h1);
    do_read(4'h4, 32'h2);
    do_read(4'h8, 32'h3);
    do_read(4'hC, 32'h4);

    fork
      do_write(4'h8, 32'h33, 4'hF, 0, 3, 1);
      begin
        repeat (2) @(negedge clk);
        check("have_a_awready", 32'(awready), 32'd0);
        check("have_a_wready", 32'(wready), 32'd1);
      end
    join
    do_read(4'h8, 32'h33);

    do_write(4'h0, 32'h77, 4'hF, 2, 0, 1);
    do_read(4'h1, 32'h77);

    do_write(4'h4, 32'hAABBCCDD, 4'hF, 0, 0, 1);
    do_write(4'h4, 32'h11223344, 4'b0101, 0, 0, 1);
    do_read(4'h4, 32'hAA22CC44);

    do_write(4'h8, 32'hFFFFFFFF, 4'h0, 0, 0, 1);
    do_read(4'h8, 32'h33);

    bready = 1'b0;
    do_write(4'h4, 32'h5A5A5A5A, 4'hF, 0, 0, 0);
    repeat (5) begin
      @(negedge clk);
      check("stall_bvalid", 32'(bvalid), 32'd1);
      check("stall_bresp", 32'(bresp), 32'd0);
      check("stall_awready", 32'(awready), 32'd0);
      check("stall_wready", 32'(wready), 32'd0);
    end
    @(posedge clk); #1;
    bready = 1'b1;
    wait_bresp();

    do_write(4'h0, 32'h5, 4'hF, 0, 0, 1);
    fork
      do_write(4'h0, 32'h9, 4'hF, 0, 0, 1);
      do_read(4'h0, 32'h5);
    join
    do_read(4'h0, 32'h9);

    do_write(4'hC, 32'hCAFE0001, 4'hF, 0, 0, 1);
    do_read(4'hC, 32'hCAFE0001);

    bready = 1'b0;
    do_write(4'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_bvalid", 32'(bvalid), 32'd0);
    check("mid_rst_awready", 32'(awready), 32'd0);
    check("mid_rst_reg_out", 32'(reg_out != '0), 32'd0);
    exp_b.delete();
    for (int i = 0; i < 4; i++) mdl[i] = '0;
    @(posedge clk); #1;
    bready = 1'b1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_bvalid", 32'(bvalid), 32'd0);
    end
    @(posedge clk); #1;
    do_read(4'h4, 32'h0);

    repeat (3) @(posedge clk);
    check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
    check("b_queue_empty", 32'(exp_b.size()), 32'd0);
    check("r_queue_empty", 32'(exp_r.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
